column_dispatcher: RTL and testbench

COLUMN_DISPATCHER -- requirements
Module: column_dispatcher

---
 rtl/column_dispatcher_pkg.sv | 16 +
 rtl/column_dispatcher.sv | 125 ++++++++++++
 tb/tb_column_dispatcher.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/column_dispatcher_pkg.sv
// Shared definitions for the column dispatcher: FSM state encoding and
// the default matrix geometry.
package column_dispatcher_pkg;

    localparam int DEF_SIZE       = 4;
    localparam int DEF_CELL_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/column_dispatcher.sv
// Feeds the columns of a latched matrix one at a time to an external column
// adder and gathers the per-column results into a single output row.
module column_dispatcher
    import column_dispatcher_pkg::*;
#(
    parameter int size       = DEF_SIZE,
    parameter int cell_width = DEF_CELL_WIDTH,
    parameter int width      = cell_width * size
) (
    input  logic                    in_clk,
    input  logic                    in_reset,
    input  logic [width*size-1:0]   in_matrix,
    input  logic                    in_ready,
    input  logic                    out_ack,
    output logic                    out_ready,
    output logic [width-1:0]        out_row,
    output logic [width-1:0]        col_data,
    output logic                    col_ready,
    output logic                    col_ack,
    input  logic                    col_result_ready,
    input  logic [cell_width-1:0]   col_result
);

    localparam int              CW       = $clog2(size + 1);
    localparam logic [CW-1:0]   LAST_COL = CW'(size - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_inc;
    logic [width*size-1:0]   r_mat;
    logic [width-1:0]        r_row;
    logic [width-1:0]        r_col;
    logic                    w_last;

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_last    = (r_cnt == LAST_COL);
    assign out_row   = r_row;
    assign col_data  = r_col;

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The adder keeps out_ready up for a cycle after seeing ack, so ACK only
    // advances once that level has gone away; this avoids a double capture.
    always_comb begin
        w_state_nxt = r_state;
        out_ready   = 1'b0;
        col_ready   = 1'b0;
        col_ack     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_ready) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                col_ready   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (col_result_ready) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                col_ack = 1'b1;
                if (!col_result_ready) begin
                    w_state_nxt = w_last ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                out_ready = 1'b1;
                if (out_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // col_data is registered when a column is selected so it holds steady
    // through WAIT and ACK regardless of what in_matrix does meanwhile.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_cnt <= '0;
            r_mat <= '0;
            r_row <= '0;
            r_col <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_ready) begin
                        r_mat <= in_matrix;
                        r_cnt <= '0;
                        r_col <= in_matrix[width-1:0];
                    end
                end
                ST_WAIT: begin
                    if (col_result_ready) begin
                        r_row[int'(r_cnt)*cell_width +: cell_width] <= col_result;
                    end
                end
                ST_ACK: begin
                    if (!col_result_ready) begin
                        r_cnt <= w_cnt_inc;
                        if (!w_last) begin
                            r_col <= r_mat[int'(w_cnt_inc)*width +: width];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_column_dispatcher.sv
// Scoreboarded bench for column_dispatcher with a behavioural column adder
// whose latency and post-ack hold time are programmable.
module tb_column_dispatcher;

    localparam int SIZE = 4;
    localparam int CELL = 32;
    localparam int W    = CELL * SIZE;

    logic              clk = 1'b0;
    logic              in_reset = 1'b1;
    logic              in_ready = 1'b0;
    logic              out_ack = 1'b0;
    logic              col_result_ready = 1'b0;
    logic [W*SIZE-1:0] in_matrix = '0;
    logic [CELL-1:0]   col_result = '0;
    logic              out_ready;
    logic              col_ready;
    logic              col_ack;
    logic [W-1:0]      out_row;
    logic [W-1:0]      col_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] col_q[$];
    logic [W-1:0] exp_q[$];

    int rsp_lat  = 3;
    int rsp_hold = 1;
    bit spur     = 1'b0;

    column_dispatcher #(.size(SIZE), .cell_width(CELL)) dut (
        .in_clk           (clk),
        .in_reset         (in_reset),
        .in_matrix        (in_matrix),
        .in_ready         (in_ready),
        .out_ack          (out_ack),
        .out_ready        (out_ready),
        .out_row          (out_row),
        .col_data         (col_data),
        .col_ready        (col_ready),
        .col_ack          (col_ack),
        .col_result_ready (col_result_ready),
        .col_result       (col_result)
    );

    always #5 clk = ~clk;

    // Integer-valued single-precision encode/decode (values 0..2^23).
    function automatic logic [31:0] enc(input int n);
        int          p;
        logic [31:0] f;
        if (n == 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 31; b++) if (n[b]) p = b;
        f = 32'(n) << (23 - p);
        return {1'b0, 8'(127 + p), f[22:0]};
    endfunction

    function automatic int dec(input logic [31:0] b);
        int          e;
        logic [23:0] m;
        if (b[30:0] == 31'h0) return 0;
        e = int'(b[30:23]) - 127;
        m = {1'b1, b[22:0]};
        return int'(m >> (23 - e));
    endfunction

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Behavioural column adder: sums the column some cycles after in_ready,
    // holds out_ready until ack plus rsp_hold cycles.
    initial begin : responder
        int          rs;
        int          left;
        int          s;
        logic [31:0] acc;
        rs = 0;
        left = 0;
        acc = '0;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                rs = 0;
                col_result_ready = 1'b0;
            end else begin
                case (rs)
                    0: begin
                        if (col_ready) begin
                            s = 0;
                            for (int i = 0; i < SIZE; i++) s += dec(col_data[i*CELL +: CELL]);
                            acc  = enc(s);
                            left = rsp_lat;
                            rs   = 1;
                        end else if (spur) begin
                            col_result_ready = 1'b1;
                            col_result       = 32'hDEADBEEF;
                            spur             = 1'b0;
                            rs               = 4;
                        end
                    end
                    1: begin
                        left--;
                        if (left <= 0) begin
                            col_result_ready = 1'b1;
                            col_result       = acc;
                            rs               = 2;
                        end
                    end
                    2: begin
                        if (col_ack) begin
                            left = rsp_hold;
                            rs   = 3;
                        end
                    end
                    3: begin
                        left--;
                        if (left <= 0) begin
                            col_result_ready = 1'b0;
                            col_result       = $urandom;
                            rs               = 0;
                        end
                    end
                    default: begin
                        col_result_ready = 1'b0;
                        rs               = 0;
                    end
                endcase
            end
        end
    end

    initial begin : monitor
        bit           prev_or;
        bit           prev_cr;
        bit           inflight;
        logic [W-1:0] held_row;
        logic [W-1:0] held_col;
        prev_or  = 1'b0;
        prev_cr  = 1'b0;
        inflight = 1'b0;
        held_row = '0;
        held_col = '0;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                prev_or  = 1'b0;
                prev_cr  = 1'b0;
                inflight = 1'b0;
            end else begin
                if (prev_cr) check_int("col_ready_single_cycle", int'(col_ready), 0);
                if (col_ready && !prev_cr) begin
                    if (col_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL col_dispatch: unexpected col_ready with col_data %h", col_data);
                    end else begin
                        check_vec("col_dispatch_order", col_data, col_q.pop_front());
                    end
                    held_col = col_data;
                    inflight = 1'b1;
                end else if (inflight) begin
                    check_vec("col_data_stable", col_data, held_col);
                    if (col_ack) inflight = 1'b0;
                end
                if (out_ready && !prev_or) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL out_row: unexpected out_ready with out_row %h", out_row);
                    end else begin
                        check_vec("out_row", out_row, exp_q.pop_front());
                    end
                    held_row = out_row;
                end else if (out_ready) begin
                    check_vec("out_row_stable", out_row, held_row);
                end
                prev_or = out_ready;
                prev_cr = col_ready;
            end
        end
    end

    task automatic do_reset();
        in_reset = 1'b1;
        in_ready = 1'b0;
        out_ack  = 1'b0;
        @(negedge clk);
        check_int("rst_out_ready", int'(out_ready), 0);
        check_int("rst_col_ready", int'(col_ready), 0);
        check_int("rst_col_ack", int'(col_ack), 0);
        check_vec("rst_out_row", out_row, '0);
        check_vec("rst_col_data", col_data, '0);
        col_q.delete();
        exp_q.delete();
        @(negedge clk);
        in_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic make_rand(output logic [W*SIZE-1:0] mat, output logic [W-1:0] exp_row);
        int v;
        int s;
        mat = '0;
        exp_row = '0;
        for (int j = 0; j < SIZE; j++) begin
            s = 0;
            for (int i = 0; i < SIZE; i++) begin
                v = int'($urandom_range(0, 15));
                s += v;
                mat[j*W + i*CELL +: CELL] = enc(v);
            end
            exp_row[j*CELL +: CELL] = enc(s);
        end
    endtask

    task automatic run_pass(input logic [W*SIZE-1:0] mat, input logic [W-1:0] exp_row,
                            input int lat, input int hold, input bit poke,
                            input bit ack_with_req, input bit do_spur);
        int cyc;
        bit seen;
        rsp_lat  = lat;
        rsp_hold = hold;
        for (int j = 0; j < SIZE; j++) col_q.push_back(mat[j*W +: W]);
        exp_q.push_back(exp_row);
        in_matrix = mat;
        in_ready  = 1'b1;
        @(negedge clk);
        in_ready  = 1'b0;
        in_matrix = {16{$urandom}};
        cyc = 1;
        while (!out_ready && cyc < 2000) begin
            in_ready = (poke && cyc == 6);
            @(negedge clk);
            cyc++;
        end
        in_ready = 1'b0;
        if (!out_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pass_timeout: out_ready still 0 after %0d cycles, required 1", cyc);
            do_reset();
            return;
        end
        if (hold == 1) begin
            n_cmp++;
            if (cyc > SIZE * (3 + lat + 1)) begin
                n_fail++;
                $display("FAIL latency: actual %0d cycles required <= %0d", cyc, SIZE * (3 + lat + 1));
            end
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
        if (do_spur) begin
            spur = 1'b1;
            repeat (3) @(negedge clk);
        end
        check_int("out_ready_held", int'(out_ready), 1);
        out_ack  = 1'b1;
        in_ready = ack_with_req;
        @(negedge clk);
        out_ack  = 1'b0;
        in_ready = 1'b0;
        check_int("out_ready_drop", int'(out_ready), 0);
        if (ack_with_req) begin
            seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                seen |= (col_ready | out_ready);
            end
            check_int("no_new_pass", int'(seen), 0);
        end
        check_int("col_pulses_consumed", col_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [W*SIZE-1:0] mat;
        logic [W-1:0]      exp_row;
        logic [W-1:0]      col;
        int                seen;
        int                cyc;

        do_reset();

        // all cells 1.0 -> every sum 4.0
        run_pass({16{32'h3F800000}}, {4{32'h40800000}}, 3, 1, 1'b0, 1'b0, 1'b0);

        // each column {1,2,3,4} -> every sum 10.0
        col = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        run_pass({4{col}}, {4{32'h41200000}}, 2, 1, 1'b0, 1'b0, 1'b0);

        // slow adder, out_ready held 3 cycles past ack
        make_rand(mat, exp_row);
        run_pass(mat, exp_row, 7, 3, 1'b0, 1'b0, 1'b0);

        // in_ready during WAIT, stray col_result_ready in DONE, in_ready+out_ack together
        make_rand(mat, exp_row);
        run_pass(mat, exp_row, 7, 1, 1'b1, 1'b1, 1'b1);

        // reset during the WAIT of column 2, then a clean pass
        make_rand(mat, exp_row);
        rsp_lat  = 7;
        rsp_hold = 1;
        for (int j = 0; j < SIZE; j++) col_q.push_back(mat[j*W +: W]);
        exp_q.push_back(exp_row);
        in_matrix = mat;
        in_ready  = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
        seen = 0;
        cyc  = 0;
        while (cyc < 500) begin
            if (col_ready) begin
                seen++;
                if (seen == 3) break;
            end
            @(negedge clk);
            cyc++;
        end
        check_int("reset_test_reached_col2", seen, 3);
        repeat (2) @(negedge clk);
        do_reset();
        make_rand(mat, exp_row);
        run_pass(mat, exp_row, 4, 1, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            make_rand(mat, exp_row);
            run_pass(mat, exp_row, int'($urandom_range(1, 8)), int'($urandom_range(1, 3)),
                     1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check_int("exp_q_drained", exp_q.size(), 0);
        check_int("col_q_drained", col_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
